// File: rtl/nios_gpio_out_pkg.sv
// Shared register offsets, STATUS bit positions and pulse FSM states for the
// nios_gpio_out Avalon-MM output port.
package nios_gpio_out_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_PULSE  = 3'd1;
    localparam logic [2:0] ADDR_PLEN   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int ST_BUSY = 0;
    localparam int ST_OVR  = 1;

    typedef enum logic {
        IDLE,
        PULSE
    } pulse_state_e;

endpackage

// File: rtl/gpio_pulse_timer.sv
// One-shot pulse engine: latches a bit mask and holds it active for max(len,1)
// cycles; a start request while a pulse is running is reported as an overrun.
module gpio_pulse_timer
    import nios_gpio_out_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic [WIDTH-1:0] active_mask_o,
    output logic             busy_o,
    output logic             overrun_pulse_o
);

    pulse_state_e     state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pmask_q, pmask_d;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pmask_q <= pmask_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pmask_d         = pmask_q;
        overrun_pulse_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && (mask_i != '0)) begin
                    pmask_d = mask_i;
                    cnt_d   = (len_i == '0) ? LEN_W'(1) : len_i;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                // Includes the final cycle: a start that coincides with the end is an overrun.
                overrun_pulse_o = start_i;
                cnt_d           = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = IDLE;
                    pmask_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = (state_q == PULSE);
    assign active_mask_o = busy_o ? pmask_q : '0;

endmodule

// File: rtl/nios_gpio_out.sv
// Avalon-MM GPIO output port: output register with atomic set/clear, one-shot
// bit inversion pulses, sticky overrun flag and a registered read mux.
module nios_gpio_out
    import nios_gpio_out_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LEN_W-1:0] plen_q, plen_d;
    logic             ovr_q, ovr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [WIDTH-1:0] active_mask;
    logic             busy;
    logic             overrun_pulse;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    logic unused_writedata;
    assign unused_writedata = ^writedata;

    gpio_pulse_timer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_timer (
        .clk             (clk),
        .rst             (reset),
        .start_i         (wr && (address == ADDR_PULSE)),
        .len_i           (plen_q),
        .mask_i          (wd),
        .active_mask_o   (active_mask),
        .busy_o          (busy),
        .overrun_pulse_o (overrun_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_VAL;
            plen_q  <= LEN_W'(1);
            ovr_q   <= 1'b0;
            rdata_q <= '0;
            out_q   <= RESET_VAL;
        end else begin
            data_q  <= data_d;
            plen_q  <= plen_d;
            ovr_q   <= ovr_d;
            rdata_q <= rdata_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        data_d = data_q;
        plen_d = plen_q;
        if (wr) begin
            unique case (address)
                ADDR_DATA:   data_d = wd;
                ADDR_OUTSET: data_d = data_q | wd;
                ADDR_OUTCLR: data_d = data_q & ~wd;
                ADDR_PLEN:   plen_d = writedata[LEN_W-1:0];
                default:     ;
            endcase
        end
    end

    // Set beats a simultaneous write-one-to-clear.
    always_comb begin
        ovr_d = ovr_q;
        if (overrun_pulse) begin
            ovr_d = 1'b1;
        end else if (wr && (address == ADDR_STATUS) && writedata[ST_OVR]) begin
            ovr_d = 1'b0;
        end
    end

    always_comb begin
        rdata_d = '0;
        unique case (address)
            ADDR_DATA:   rdata_d[WIDTH-1:0] = data_q;
            ADDR_PULSE:  rdata_d[WIDTH-1:0] = active_mask;
            ADDR_PLEN:   rdata_d[LEN_W-1:0] = plen_q;
            ADDR_STATUS: begin
                rdata_d[ST_BUSY] = busy;
                rdata_d[ST_OVR]  = ovr_q;
            end
            default:     rdata_d = '0;
        endcase
    end

    assign out_d = data_q ^ active_mask;

    assign readdata = rdata_q;
    assign out_port = out_q;

endmodule
